// File: rtl/ddr2_cmd_monitor.sv
// DDR2 command-bus monitor: per-bank open/closed tracking, protocol rule checks and command counters.
// Optional macro DDR2_MON_TIMING_EN adds per-bank tRCD/tRP down-counters (error codes 4 and 5).
//
// state     | meaning
// ST_CLOSED | bank precharged, only ACT is legal
// ST_OPEN   | row active, RD/WR legal, ACT/REF/MRS are violations
module ddr2_cmd_monitor #(
  parameter int BA_BITS   = 2,
  parameter int ADDR_BITS = 13,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int CNT_W     = 16
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  cke,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BA_BITS-1:0]    ba,
  input  logic [ADDR_BITS-1:0]  addr,
  output logic [2**BA_BITS-1:0] bank_open,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [BA_BITS-1:0]    err_bank,
  output logic                  err_sticky,
  output logic [2:0]            first_code,
  output logic [CNT_W-1:0]      cnt_act,
  output logic [CNT_W-1:0]      cnt_rd,
  output logic [CNT_W-1:0]      cnt_wr,
  output logic [CNT_W-1:0]      cnt_pre,
  output logic [CNT_W-1:0]      cnt_ref
);
  localparam int NB = 2**BA_BITS;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_RSV = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic {ST_CLOSED = 1'b0, ST_OPEN = 1'b1} bank_st_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN  = 3'd1;
  localparam logic [2:0] ERR_RW_CLOSED = 3'd2;
  localparam logic [2:0] ERR_REF_OPEN  = 3'd3;
  localparam logic [2:0] ERR_TRCD      = 3'd4;
  localparam logic [2:0] ERR_TRP       = 3'd5;
  localparam logic [2:0] ERR_MRS_OPEN  = 3'd6;

  cmd_e               cmd;
  bank_st_e           bank_st [NB];
  logic               any_open;
  logic               sel_open;
  logic               pre_all;
  logic [2:0]         code_nxt;
  logic [BA_BITS-1:0] bank_nxt;
  logic               unused_addr;

  // Only addr[10] matters to the checks; the rest of the bus is observed but ignored.
  assign unused_addr = ^addr;

  assign cmd      = (cke && !cs_n) ? cmd_e'({ras_n, cas_n, we_n}) : CMD_NOP;
  assign pre_all  = addr[10];
  assign sel_open = (bank_st[ba] == ST_OPEN);

  always_comb begin
    any_open  = 1'b0;
    bank_open = '0;
    for (int i = 0; i < NB; i++) begin
      bank_open[i] = (bank_st[i] == ST_OPEN);
      if (bank_st[i] == ST_OPEN) any_open = 1'b1;
    end
  end

`ifdef DDR2_MON_TIMING_EN
  // A single timer per bank suffices: while OPEN it holds tRCD, while CLOSED it holds tRP.
  localparam logic [3:0] TRCD_LD = 4'(T_RCD - 1);
  localparam logic [3:0] TRP_LD  = 4'(T_RP - 1);

  logic [3:0] tmr [NB];
  logic       tmr_busy;

  assign tmr_busy = (tmr[ba] != 4'd0);

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) tmr[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (cmd == CMD_ACT && ba == BA_BITS'(i))
          tmr[i] <= TRCD_LD;
        else if (cmd == CMD_PRE && (pre_all || ba == BA_BITS'(i)))
          tmr[i] <= TRP_LD;
        else if (tmr[i] != 4'd0)
          tmr[i] <= tmr[i] - 4'd1;
      end
    end
  end
`else
  localparam int unused_timing = T_RCD + T_RP;
`endif

  always_comb begin
    code_nxt = ERR_NONE;
    bank_nxt = ba;
    case (cmd)
      CMD_ACT: begin
        if (sel_open) code_nxt = ERR_ACT_OPEN;
`ifdef DDR2_MON_TIMING_EN
        else if (tmr_busy) code_nxt = ERR_TRP;
`endif
      end
      CMD_RD, CMD_WR: begin
        if (!sel_open) code_nxt = ERR_RW_CLOSED;
`ifdef DDR2_MON_TIMING_EN
        else if (tmr_busy) code_nxt = ERR_TRCD;
`endif
      end
      CMD_REF: begin
        bank_nxt = '0;
        if (any_open) code_nxt = ERR_REF_OPEN;
      end
      CMD_MRS: begin
        bank_nxt = '0;
        if (any_open) code_nxt = ERR_MRS_OPEN;
      end
      default: ;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) bank_st[i] <= ST_CLOSED;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      err_bank   <= '0;
      err_sticky <= 1'b0;
      first_code <= ERR_NONE;
      cnt_act    <= '0;
      cnt_rd     <= '0;
      cnt_wr     <= '0;
      cnt_pre    <= '0;
      cnt_ref    <= '0;
    end else begin
      // Bank state follows the command even when it is flagged as a violation.
      for (int i = 0; i < NB; i++) begin
        if (cmd == CMD_ACT && ba == BA_BITS'(i))
          bank_st[i] <= ST_OPEN;
        else if (cmd == CMD_PRE && (pre_all || ba == BA_BITS'(i)))
          bank_st[i] <= ST_CLOSED;
      end

      err_valid <= (code_nxt != ERR_NONE);
      err_code  <= code_nxt;
      err_bank  <= (code_nxt != ERR_NONE) ? bank_nxt : '0;
      if (code_nxt != ERR_NONE && !err_sticky) begin
        err_sticky <= 1'b1;
        first_code <= code_nxt;
      end

      if (cmd == CMD_ACT) cnt_act <= sat_inc(cnt_act);
      if (cmd == CMD_RD)  cnt_rd  <= sat_inc(cnt_rd);
      if (cmd == CMD_WR)  cnt_wr  <= sat_inc(cnt_wr);
      if (cmd == CMD_PRE) cnt_pre <= sat_inc(cnt_pre);
      if (cmd == CMD_REF) cnt_ref <= sat_inc(cnt_ref);
    end
  end

endmodule

// File: tb/tb_ddr2_cmd_monitor.sv
// Bench for ddr2_cmd_monitor: timestamp-based reference model checked every cycle, plus directed literals.
module tb_ddr2_cmd_monitor;
  localparam int BA_BITS = 2, ADDR_BITS = 13, T_RCD = 3, T_RP = 3;
  localparam int CNT_W = 16, CNT_WS = 3, NB = 4;
  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;
`ifdef DDR2_MON_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif

  logic ck = 1'b0, rst = 1'b1;
  logic cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [BA_BITS-1:0] ba = '0;
  logic [ADDR_BITS-1:0] addr = '0;

  logic [NB-1:0] m_open, s_open;
  logic m_ev, s_ev, m_sticky, s_sticky;
  logic [2:0] m_code, s_code, m_first, s_first;
  logic [BA_BITS-1:0] m_bank, s_bank;
  logic [CNT_W-1:0] m_act, m_rd, m_wr, m_pre, m_ref;
  logic [CNT_WS-1:0] s_act, s_rd, s_wr, s_pre, s_ref;

  int vectors = 0, miscompares = 0;

  always #5 ck = ~ck;

  ddr2_cmd_monitor #(.BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS), .T_RCD(T_RCD), .T_RP(T_RP),
                     .CNT_W(CNT_W)) dut (
    .ck(ck), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .bank_open(m_open), .err_valid(m_ev), .err_code(m_code),
    .err_bank(m_bank), .err_sticky(m_sticky), .first_code(m_first),
    .cnt_act(m_act), .cnt_rd(m_rd), .cnt_wr(m_wr), .cnt_pre(m_pre), .cnt_ref(m_ref));

  // Narrow-counter copy so saturation is reachable in a short run.
  ddr2_cmd_monitor #(.BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS), .T_RCD(T_RCD), .T_RP(T_RP),
                     .CNT_W(CNT_WS)) dut_s (
    .ck(ck), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .bank_open(s_open), .err_valid(s_ev), .err_code(s_code),
    .err_bank(s_bank), .err_sticky(s_sticky), .first_code(s_first),
    .cnt_act(s_act), .cnt_rd(s_rd), .cnt_wr(s_wr), .cnt_pre(s_pre), .cnt_ref(s_ref));

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Reference model: bank state as flags, timing as absolute cycle stamps of the last ACT/PRE.
  int  cyc = 0;
  bit  md_open [NB];
  int  act_t [NB], pre_t [NB];
  int  n_act, n_rd, n_wr, n_pre, n_ref;
  bit  e_valid, e_sticky, model_ok = 0;
  int  e_code, e_bank, e_first;

  always @(posedge ck) begin : model
    int c, b;
    bit any;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        md_open[i] = 0; act_t[i] = -1000; pre_t[i] = -1000;
      end
      n_act = 0; n_rd = 0; n_wr = 0; n_pre = 0; n_ref = 0;
      e_valid = 0; e_code = 0; e_bank = 0; e_sticky = 0; e_first = 0;
      model_ok = 1;
    end else begin
      b = int'(ba);
      any = 0;
      for (int i = 0; i < NB; i++) if (md_open[i]) any = 1;
      c = (cke && !cs_n) ? int'({ras_n, cas_n, we_n}) : 7;
      e_code = 0;
      e_bank = 0;
      case (c)
        3: begin
          n_act++;
          if (md_open[b]) e_code = 1;
          else if (TIMING && (cyc - pre_t[b]) < T_RP) e_code = 5;
          md_open[b] = 1; act_t[b] = cyc; e_bank = b;
        end
        4, 5: begin
          if (c == 5) n_rd++; else n_wr++;
          if (!md_open[b]) e_code = 2;
          else if (TIMING && (cyc - act_t[b]) < T_RCD) e_code = 4;
          e_bank = b;
        end
        2: begin
          n_pre++;
          for (int i = 0; i < NB; i++)
            if (addr[10] || i == b) begin md_open[i] = 0; pre_t[i] = cyc; end
        end
        1: begin n_ref++; if (any) e_code = 3; end
        0: if (any) e_code = 6;
        default: ;
      endcase
      e_valid = (e_code != 0);
      if (!e_valid) e_bank = 0;
      if (e_valid && !e_sticky) begin e_sticky = 1; e_first = e_code; end
    end
  end

  always @(negedge ck) begin : compare
    int ov;
    if (model_ok) begin
      ov = 0;
      for (int i = 0; i < NB; i++) if (md_open[i]) ov |= (1 << i);
      chk("bank_open", m_open, ov);
      chk("err_valid", m_ev, e_valid);
      chk("err_code", m_code, e_code);
      chk("err_bank", m_bank, e_bank);
      chk("err_sticky", m_sticky, e_sticky);
      chk("first_code", m_first, e_first);
      chk("cnt_act", m_act, sat(n_act, CNT_W));
      chk("cnt_rd", m_rd, sat(n_rd, CNT_W));
      chk("cnt_wr", m_wr, sat(n_wr, CNT_W));
      chk("cnt_pre", m_pre, sat(n_pre, CNT_W));
      chk("cnt_ref", m_ref, sat(n_ref, CNT_W));
      chk("s_bank_open", s_open, ov);
      chk("s_err_code", s_code, e_code);
      chk("s_first_code", s_first, e_first);
      chk("s_cnt_act", s_act, sat(n_act, CNT_WS));
      chk("s_cnt_rd", s_rd, sat(n_rd, CNT_WS));
      chk("s_cnt_wr", s_wr, sat(n_wr, CNT_WS));
      chk("s_cnt_pre", s_pre, sat(n_pre, CNT_WS));
      chk("s_cnt_ref", s_ref, sat(n_ref, CNT_WS));
    end
  end

  // Drive one cycle of pins, return 2 time units after the edge with the bus back at NOP.
  task automatic pins(input logic k, input logic cs, input logic [2:0] c, input int b,
                      input logic [ADDR_BITS-1:0] a);
    cke = k; cs_n = cs; {ras_n, cas_n, we_n} = c; ba = BA_BITS'(b); addr = a;
    @(posedge ck);
    #2;
    cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
  endtask

  task automatic issue(input logic [2:0] c, input int b, input bit a10);
    pins(1'b1, 1'b0, c, b, a10 ? 13'h0400 : 13'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge ck); #2; end
  endtask

  initial begin
    logic [2:0] rc;
    // Pins active during reset must be ignored.
    issue(C_ACT, 0, 0);
    issue(C_REF, 0, 0);
    chk("rst_bank_open", m_open, 0);
    chk("rst_cnt_act", m_act, 0);
    chk("rst_cnt_ref", m_ref, 0);
    chk("rst_err_valid", m_ev, 0);
    rst = 1'b0;

    // ACT b0, RD b0 exactly T_RCD later: legal.
    issue(C_ACT, 0, 0);
    idle(2);
    issue(C_RD, 0, 0);
    chk("a_err_valid", m_ev, 0);
    chk("a_cnt_act", m_act, 1);
    chk("a_cnt_rd", m_rd, 1);
    chk("a_bank_open", m_open, 4'b0001);
    issue(C_PRE, 0, 1);
    idle(4);

    // WR one cycle after ACT: tRCD violation only with timing checks built in.
    issue(C_ACT, 1, 0);
    issue(C_WR, 1, 0);
    chk("b_err_valid", m_ev, TIMING ? 1 : 0);
    chk("b_err_code", m_code, TIMING ? 4 : 0);
    chk("b_err_bank", m_bank, TIMING ? 1 : 0);

    // Mid-run reset discards everything, pins included.
    rst = 1'b1;
    issue(C_ACT, 3, 0);
    chk("r_bank_open", m_open, 0);
    chk("r_cnt_act", m_act, 0);
    chk("r_cnt_wr", m_wr, 0);
    chk("r_err_sticky", m_sticky, 0);
    chk("r_first_code", m_first, 0);
    rst = 1'b0;

    // Double ACT, then RD to a closed bank: sticky keeps the first code.
    issue(C_ACT, 2, 0);
    issue(C_ACT, 2, 0);
    chk("c_err_code", m_code, 1);
    chk("c_err_bank", m_bank, 2);
    chk("c_first_code", m_first, 1);
    issue(C_RD, 3, 0);
    chk("c_err_code2", m_code, 2);
    chk("c_err_bank2", m_bank, 3);
    chk("c_first_code2", m_first, 1);
    idle(1);
    chk("c_pulse_end", m_ev, 0);

    // PRE-all then ACT one cycle later (tRP), then REF and MRS with a bank open.
    issue(C_ACT, 0, 0);
    issue(C_ACT, 1, 0);
    issue(C_PRE, 0, 1);
    chk("d_bank_open", m_open, 0);
    issue(C_ACT, 1, 0);
    chk("d_trp_code", m_code, TIMING ? 5 : 0);
    chk("d_trp_bank", m_bank, TIMING ? 1 : 0);
    issue(C_REF, 1, 0);
    chk("d_ref_code", m_code, 3);
    chk("d_ref_bank", m_bank, 0);
    issue(C_MRS, 2, 0);
    chk("d_mrs_code", m_code, 6);
    issue(C_PRE, 0, 1);
    idle(4);
    issue(C_REF, 0, 0);
    chk("d_ref_ok", m_ev, 0);
    issue(C_MRS, 0, 0);
    chk("d_mrs_ok", m_ev, 0);

    // Deselected or clock-disabled commands are NOPs.
    pins(1'b1, 1'b1, C_ACT, 0, 13'h0);
    pins(1'b0, 1'b0, C_ACT, 0, 13'h0);
    chk("e_nop_open", m_open, 0);

    // tRCD one short, then tRP met exactly.
    issue(C_ACT, 0, 0);
    idle(1);
    issue(C_RD, 0, 0);
    chk("f_trcd_code", m_code, TIMING ? 4 : 0);
    issue(C_PRE, 0, 0);
    idle(2);
    issue(C_ACT, 0, 0);
    chk("f_trp_ok", m_ev, 0);

    // Saturation of the narrow counter.
    repeat (9) issue(C_PRE, 1, 0);
    chk("g_sat_pre", s_pre, 7);

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b1;
        issue(C_NOP, 0, 0);
        rst = 1'b0;
      end else begin
        rc = 3'($urandom_range(0, 7));
        pins(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 7) == 0), rc,
             int'($urandom_range(0, NB - 1)),
             ADDR_BITS'(($urandom & 32'h1BFF) | (($urandom_range(0, 3) == 0) ? 32'h400 : 0)));
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
